// File: rtl/vec_mask_pkg.sv
// vec_mask_pkg: shared widths, carry-save pair type and FSM states for the mask-popcount accumulator.
package vec_mask_pkg;
   localparam int CHUNK = 64;
   localparam int CS_W  = 7;
   typedef logic [1:0][CS_W-1:0] cs_pair_t;
   typedef enum logic [1:0] {IDLE, ACC, DONE} popc_state_e;
endpackage

// File: rtl/cs_resolve.sv
// cs_resolve: resolves a 7+7 carry-save pair to an 8-bit beat count and flags sums above one chunk.
module cs_resolve
   import vec_mask_pkg::*;
(
   input  cs_pair_t   cs_i,
   output logic [7:0] sum_o,
   output logic       ovf_o
);
   assign sum_o = 8'(cs_i[0]) + 8'(cs_i[1]);
   assign ovf_o = sum_o > 8'(CHUNK);
endmodule

// File: rtl/mask_popc_accum.sv
// mask_popc_accum: accumulates resolved per-chunk popcounts over a multi-beat mask and returns one count.
module mask_popc_accum
   import vec_mask_pkg::*;
#(
   parameter  int VLEN   = 256,
   localparam int NBEATS = VLEN / CHUNK,
   localparam int CNT_W  = $clog2(VLEN + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  cs_pair_t         in_cs_i,
   input  logic             in_last_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [CNT_W-1:0] out_count_o,
   output logic             out_zero_o,
   output logic             err_o
);
   localparam int BC_W = $clog2(NBEATS + 1);

   popc_state_e      state_q;
   logic [CNT_W-1:0] acc_q, acc_d, out_count_q;
   logic [BC_W-1:0]  beat_cnt_q;
   logic             out_valid_q, out_zero_q, err_q;
   logic             accept, cap, last;
   logic [7:0]       sum;
   logic             ovf;

   cs_resolve u_resolve (.cs_i(in_cs_i), .sum_o(sum), .ovf_o(ovf));

   assign in_ready_o = state_q != DONE;
   assign accept     = in_valid_i & in_ready_o;
   // The NBEATS-th beat closes the instruction even without last, so the FSM cannot hang.
   assign cap        = beat_cnt_q == BC_W'(NBEATS - 1);
   assign last       = in_last_i | cap;
   assign acc_d      = acc_q + CNT_W'(sum);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         acc_q       <= '0;
         beat_cnt_q  <= '0;
         out_valid_q <= 1'b0;
         out_count_q <= '0;
         out_zero_q  <= 1'b0;
         err_q       <= 1'b0;
      end else if (flush_i) begin
         state_q     <= IDLE;
         acc_q       <= '0;
         beat_cnt_q  <= '0;
         out_valid_q <= 1'b0;
      end else if (accept) begin
         err_q <= err_q | ovf | (cap & ~in_last_i);
         if (last) begin
            state_q     <= DONE;
            acc_q       <= '0;
            beat_cnt_q  <= '0;
            out_valid_q <= 1'b1;
            out_count_q <= acc_d;
            out_zero_q  <= acc_d == '0;
         end else begin
            state_q    <= ACC;
            acc_q      <= acc_d;
            beat_cnt_q <= beat_cnt_q + BC_W'(1);
         end
      end else if (state_q == DONE && out_ready_i) begin
         state_q     <= IDLE;
         out_valid_q <= 1'b0;
      end
   end

   assign out_valid_o = out_valid_q;
   assign out_count_o = out_count_q;
   assign out_zero_o  = out_zero_q;
   assign err_o       = err_q;
endmodule

// File: tb/tb_mask_popc_accum.sv
// tb_mask_popc_accum: directed and randomized checks of mask_popc_accum against a running-sum model.
module tb_mask_popc_accum;
   import vec_mask_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n, flush, in_valid, in_ready, last, out_valid, out_ready, out_zero, err;
   cs_pair_t   cs;
   logic [8:0] out_count;
   int         n_assert = 0;
   int         n_fail = 0;

   always #5 clk = ~clk;

   mask_popc_accum #(.VLEN(256)) dut (
      .clk(clk), .rst_n(rst_n), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(in_ready),
      .in_cs_i(cs), .in_last_i(last), .out_valid_o(out_valid), .out_ready_i(out_ready),
      .out_count_o(out_count), .out_zero_o(out_zero), .err_o(err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic beat(input int c0, input int c1, input bit l);
      @(negedge clk);
      chk("in_ready_beat", 32'(in_ready), 1);
      in_valid = 1'b1;
      cs[0] = 7'(c0);
      cs[1] = 7'(c1);
      last = l;
      @(negedge clk);
      in_valid = 1'b0;
      last = 1'b0;
   endtask

   task automatic finish(input int exp, input int hold);
      chk("out_valid", 32'(out_valid), 1);
      chk("count", 32'(out_count), 32'(exp));
      chk("zero", 32'(out_zero), 32'(exp == 0));
      chk("in_ready_done", 32'(in_ready), 0);
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         chk("hold_valid", 32'(out_valid), 1);
         chk("hold_count", 32'(out_count), 32'(exp));
         chk("hold_zero", 32'(out_zero), 32'(exp == 0));
         chk("hold_in_ready", 32'(in_ready), 0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("valid_drop", 32'(out_valid), 0);
      chk("in_ready_idle", 32'(in_ready), 1);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; last = 1'b0; out_ready = 1'b0; cs = '0;
      repeat (2) @(negedge clk);
      chk("rst_valid", 32'(out_valid), 0);
      chk("rst_count", 32'(out_count), 0);
      chk("rst_zero", 32'(out_zero), 0);
      chk("rst_err", 32'(err), 0);
      chk("rst_in_ready", 32'(in_ready), 1);
      rst_n = 1'b1;

      beat(20, 12, 1);
      finish(32, 0);
      chk("err_clean", 32'(err), 0);

      for (int b = 0; b < 4; b++) begin
         beat(32, 32, b == 3);
         if (b < 3) chk("acc_no_valid", 32'(out_valid), 0);
      end
      finish(256, 0);

      beat(0, 0, 0);
      beat(0, 0, 1);
      finish(0, 5);

      for (int k = 0; k < 10; k++) begin
         int nb, tot, c0, c1;
         nb = int'($urandom_range(1, 4));
         tot = 0;
         for (int b = 0; b < nb; b++) begin
            c0 = int'($urandom_range(0, 64));
            c1 = int'($urandom_range(0, 64 - c0));
            tot += c0 + c1;
            beat(c0, c1, b == nb - 1);
            if (b < nb - 1) chk("rnd_no_valid", 32'(out_valid), 0);
         end
         finish(tot, int'($urandom_range(0, 3)));
      end
      chk("rnd_err", 32'(err), 0);

      beat(10, 10, 0);
      beat(15, 5, 0);
      @(negedge clk);
      flush = 1'b1; in_valid = 1'b1; cs[0] = 7'd30; cs[1] = 7'd30; last = 1'b1;
      @(negedge clk);
      flush = 1'b0; in_valid = 1'b0; last = 1'b0;
      chk("flush_valid", 32'(out_valid), 0);
      chk("flush_in_ready", 32'(in_ready), 1);
      beat(2, 3, 1);
      finish(5, 0);

      beat(1, 1, 1);
      @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk("flush_done_valid", 32'(out_valid), 0);
      chk("flush_done_in_ready", 32'(in_ready), 1);

      beat(3, 4, 1);
      chk("sim_valid", 32'(out_valid), 1);
      out_ready = 1'b1; in_valid = 1'b1; cs[0] = 7'd9; cs[1] = 7'd9; last = 1'b1;
      @(negedge clk);
      out_ready = 1'b0; in_valid = 1'b0; last = 1'b0;
      chk("sim_drop", 32'(out_valid), 0);
      @(negedge clk);
      chk("sim_not_taken", 32'(out_valid), 0);
      chk("sim_err", 32'(err), 0);

      beat(60, 10, 1);
      chk("ovf_err", 32'(err), 1);
      finish(70, 0);
      for (int b = 0; b < 4; b++) begin
         beat(1, 1, 0);
         if (b < 3) chk("cap_no_valid", 32'(out_valid), 0);
      end
      finish(8, 0);
      chk("err_sticky", 32'(err), 1);

      beat(5, 5, 0);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("arst_acc_valid", 32'(out_valid), 0);
      chk("arst_acc_err", 32'(err), 0);
      chk("arst_acc_count", 32'(out_count), 0);
      @(negedge clk);
      rst_n = 1'b1;
      beat(4, 4, 1);
      finish(8, 0);

      beat(6, 6, 1);
      chk("pre_rst_valid", 32'(out_valid), 1);
      rst_n = 1'b0;
      #1;
      chk("arst_done_valid", 32'(out_valid), 0);
      chk("arst_done_count", 32'(out_count), 0);
      chk("arst_done_zero", 32'(out_zero), 0);
      chk("arst_done_in_ready", 32'(in_ready), 1);
      @(negedge clk);
      rst_n = 1'b1;
      beat(1, 2, 1);
      finish(3, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
